// File: rtl/sti_dac_gen.sv
// -----------------------------------------------------------------------------
// sti_dac_gen : serial transmitter plus pixel-memory arrangement controller.
//
// A parallel word is built into a 1..4 pixel frame. The frame is shifted out
// on so_data/so_valid. The same bits, grouped PIX_W at a time, are written as
// pixels to incrementing memory addresses. On pi_end the rest of the memory
// is zero-filled and pixel_finish is raised.
//
// Optional build macro:
//   STI_PARITY_EN - appends one even-parity bit after each serial frame.
//
// Parameters: PIX_W (bits per pixel, >= 2), ADDR_W (pixel address width).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load, pi_data       frame request (IDLE only) and 2*PIX_W-bit payload
//   pi_length           frame length in pixels minus 1
//   pi_fill/pi_low      payload placement for long/short frames
//   pi_msb              1 = transmit MSB first
//   pi_end              start zero-fill of the remaining memory
//   ready               FSM is IDLE (a load is taken this cycle)
//   so_data, so_valid   serial output
//   pixel_wr/addr/dataout  pixel memory write port
//   pixel_finish        memory fully written (sticky)
// -----------------------------------------------------------------------------
module sti_dac_gen #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [2*PIX_W-1:0]   pi_data,
  input  logic [1:0]           pi_length,
  input  logic                 pi_fill,
  input  logic                 pi_msb,
  input  logic                 pi_low,
  input  logic                 pi_end,
  output logic                 ready,
  output logic                 so_data,
  output logic                 so_valid,
  output logic                 pixel_wr,
  output logic [ADDR_W-1:0]    pixel_addr,
  output logic [PIX_W-1:0]     pixel_dataout,
  output logic                 pixel_finish
);

  localparam int DATA_W = 2 * PIX_W;
  localparam int MAX_W  = 4 * PIX_W;
  localparam int CNT_W  = $clog2(MAX_W + 2);
  localparam int GRP_W  = $clog2(PIX_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [MAX_W-1:0]   r_frame, w_frame, w_src;
  logic [CNT_W-1:0]   r_fw, w_fw_in, w_fw, r_bcnt, w_k, w_idx, w_nbits;
  logic               r_msb, w_msb;
  logic [GRP_W-1:0]   r_gcnt, w_g;
  logic [PIX_W-1:0]   r_pix, w_pix_nxt;
  logic [ADDR_W:0]    r_wcnt;
  logic               w_load_acc, w_emit, w_is_frame, w_frame_bit, w_grp_end;
  logic               w_wr_shift, w_wr_fill, w_bit, w_par_bit, w_wcnt_last;
  logic               r_so_data, r_so_valid, r_pixel_wr, r_finish;
  logic [ADDR_W-1:0]  r_pixel_addr;
  logic [PIX_W-1:0]   r_pixel_data;

  // Frame build from the load-time controls; unused frame bits are zero.
  always_comb begin
    w_frame = '0;
    w_fw_in = CNT_W'(PIX_W) * CNT_W'({1'b0, pi_length} + 3'd1);
    case (pi_length)
      2'd0: begin
        if (pi_low) w_frame = MAX_W'(pi_data[DATA_W-1 -: PIX_W]);
        else        w_frame = MAX_W'(pi_data[PIX_W-1:0]);
      end
      2'd1: w_frame = MAX_W'(pi_data);
      2'd2: begin
        if (pi_fill) w_frame = MAX_W'(pi_data) << PIX_W;
        else         w_frame = MAX_W'(pi_data);
      end
      2'd3: begin
        if (pi_fill) w_frame = MAX_W'(pi_data) << DATA_W;
        else         w_frame = MAX_W'(pi_data);
      end
      default: w_frame = '0;
    endcase
  end

  // Bit selection and pixel/write decisions; in IDLE the first bit comes
  // straight from the input frame so it appears the cycle after load.
  always_comb begin
    w_load_acc = (r_state == S_IDLE) && load;
    w_src      = (r_state == S_IDLE) ? w_frame : r_frame;
    w_fw       = (r_state == S_IDLE) ? w_fw_in : r_fw;
    w_msb      = (r_state == S_IDLE) ? pi_msb  : r_msb;
    w_k        = (r_state == S_IDLE) ? '0      : r_bcnt;
    w_g        = (r_state == S_IDLE) ? '0      : r_gcnt;
`ifdef STI_PARITY_EN
    w_nbits    = r_fw + CNT_W'(1);
    w_par_bit  = ^r_frame;
`else
    w_nbits    = r_fw;
    w_par_bit  = 1'b0;
`endif
    w_idx       = w_msb ? (w_fw - w_k - CNT_W'(1)) : w_k;
    w_is_frame  = (w_k < w_fw);
    // Mask-select keeps every frame bit in use (no dangling shifter bits).
    w_bit       = w_is_frame ? |(w_src & (MAX_W'(1) << w_idx)) : w_par_bit;
    w_emit      = w_load_acc || ((r_state == S_SHIFT) && (r_bcnt != w_nbits));
    w_frame_bit = w_emit && w_is_frame;
    w_grp_end   = w_frame_bit && (w_g == GRP_W'(PIX_W - 1));
    w_pix_nxt   = {r_pix[PIX_W-2:0], w_bit};
    // wcnt MSB set means the memory is full: writes are suppressed.
    w_wr_shift  = w_grp_end && !r_wcnt[ADDR_W];
    w_wr_fill   = (r_state == S_FILL);
    w_wcnt_last = (r_wcnt[ADDR_W-1:0] == {ADDR_W{1'b1}});
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (load)            w_state_nxt = S_SHIFT;
        else if (pi_end)     w_state_nxt = r_wcnt[ADDR_W] ? S_DONE : S_FILL;
        else                 w_state_nxt = S_IDLE;
      end
      S_SHIFT: begin
        if (r_bcnt == w_nbits) w_state_nxt = S_IDLE;
        else                   w_state_nxt = S_SHIFT;
      end
      S_FILL: begin
        if (w_wcnt_last) w_state_nxt = S_DONE;
        else             w_state_nxt = S_FILL;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath: frame capture, serial output, pixel assembly and writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame      <= '0;
      r_fw         <= '0;
      r_msb        <= 1'b0;
      r_bcnt       <= '0;
      r_gcnt       <= '0;
      r_pix        <= '0;
      r_wcnt       <= '0;
      r_so_data    <= 1'b0;
      r_so_valid   <= 1'b0;
      r_pixel_wr   <= 1'b0;
      r_pixel_addr <= '0;
      r_pixel_data <= '0;
      r_finish     <= 1'b0;
    end else begin
      if (w_load_acc) begin
        r_frame <= w_frame;
        r_fw    <= w_fw_in;
        r_msb   <= pi_msb;
      end
      if (w_emit) begin
        r_so_valid <= 1'b1;
        r_so_data  <= w_bit;
        r_bcnt     <= w_k + CNT_W'(1);
      end else begin
        r_so_valid <= 1'b0;   // so_data holds its last value
      end
      if (w_frame_bit) begin
        r_pix  <= w_pix_nxt;
        r_gcnt <= w_grp_end ? '0 : (w_g + GRP_W'(1));
      end
      if (w_wr_shift) begin
        r_pixel_wr   <= 1'b1;
        r_pixel_addr <= r_wcnt[ADDR_W-1:0];
        r_pixel_data <= w_pix_nxt;
        r_wcnt       <= r_wcnt + (ADDR_W+1)'(1);
      end else if (w_wr_fill) begin
        r_pixel_wr   <= 1'b1;
        r_pixel_addr <= r_wcnt[ADDR_W-1:0];
        r_pixel_data <= '0;
        r_wcnt       <= r_wcnt + (ADDR_W+1)'(1);
      end else begin
        r_pixel_wr   <= 1'b0;
      end
      // Rises the cycle after DONE is entered, i.e. after the last fill write.
      if (r_state == S_DONE) r_finish <= 1'b1;
    end
  end

  assign ready         = (r_state == S_IDLE);
  assign so_data       = r_so_data;
  assign so_valid      = r_so_valid;
  assign pixel_wr      = r_pixel_wr;
  assign pixel_addr    = r_pixel_addr;
  assign pixel_dataout = r_pixel_data;
  assign pixel_finish  = r_finish;

endmodule

// File: tb/tb_sti_dac_gen.sv
module tb_sti_dac_gen;

  logic        clk = 1'b0;
  logic        reset, load, pi_fill, pi_msb, pi_low, pi_end;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;

  logic       a_ready, a_so_data, a_so_valid, a_wr, a_finish;
  logic [7:0] a_addr, a_dout;
  logic       b_ready, b_so_data, b_so_valid, b_wr, b_finish;
  logic [1:0] b_addr;
  logic [7:0] b_dout;

  logic       sel = 1'b0;
  logic       o_ready, o_so_data, o_so_valid, o_wr, o_finish;
  logic [7:0] o_addr, o_dout;

  int n_chk  = 0;
  int n_fail = 0;
  int mw     = 0;
  int depth  = 256;

  always #5 clk = ~clk;

  sti_dac_gen #(.PIX_W(8), .ADDR_W(8)) dut_a (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .ready(a_ready), .so_data(a_so_data),
    .so_valid(a_so_valid), .pixel_wr(a_wr), .pixel_addr(a_addr),
    .pixel_dataout(a_dout), .pixel_finish(a_finish));

  sti_dac_gen #(.PIX_W(8), .ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .ready(b_ready), .so_data(b_so_data),
    .so_valid(b_so_valid), .pixel_wr(b_wr), .pixel_addr(b_addr),
    .pixel_dataout(b_dout), .pixel_finish(b_finish));

  assign o_ready    = sel ? b_ready    : a_ready;
  assign o_so_data  = sel ? b_so_data  : a_so_data;
  assign o_so_valid = sel ? b_so_valid : a_so_valid;
  assign o_wr       = sel ? b_wr       : a_wr;
  assign o_finish   = sel ? b_finish   : a_finish;
  assign o_addr     = sel ? {6'd0, b_addr} : a_addr;
  assign o_dout     = sel ? b_dout     : a_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; pi_end = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mw = 0;
  endtask

  // Reference: frame from the placement rules, bit order, PIX_W grouping,
  // and a saturating write count against the memory depth.
  task automatic run_frame(input logic [15:0] d, input logic [1:0] len,
                           input logic fill, input logic msb, input logic low,
                           input bit with_end, input bit poke);
    logic [63:0] fr;
    logic        bits[$];
    logic [7:0]  pix;
    int          fw;
    bit          exp_wr;
    fw = (int'(len) + 1) * 8;
    if (fw < 16)       fr = low ? 64'(d >> (16 - fw)) : (64'(d) & ((64'd1 << fw) - 64'd1));
    else if (fw == 16) fr = 64'(d);
    else               fr = fill ? (64'(d) << (fw - 16)) : 64'(d);
    for (int i = 0; i < fw; i++) bits.push_back(msb ? fr[fw-1-i] : fr[i]);
`ifdef STI_PARITY_EN
    bits.push_back(^fr);
`endif
    for (int c = 0; c < 50 && o_ready !== 1'b1; c++) begin @(posedge clk); #1; end
    chk("ready_before_load", 64'(o_ready), 64'd1);
    pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low;
    load = 1'b1; pi_end = with_end ? 1'b1 : 1'b0;
    @(posedge clk); #1;
    load = 1'b0; pi_end = 1'b0;
    pix = 8'd0;
    for (int i = 0; i < bits.size(); i++) begin
      if (poke && i == 3) begin load = 1'b1; pi_end = 1'b1; pi_data = ~d; pi_msb = ~msb; end
      if (poke && i == bits.size() - 2) begin load = 1'b0; pi_end = 1'b0; end
      chk("so_valid", 64'(o_so_valid), 64'd1);
      chk("so_data", 64'(o_so_data), 64'(bits[i]));
      chk("ready_busy", 64'(o_ready), 64'd0);
      exp_wr = 1'b0;
      if (i < fw) begin
        pix = {pix[6:0], bits[i]};
        exp_wr = ((i % 8) == 7) && (mw < depth);
      end
      chk("pixel_wr", 64'(o_wr), 64'(exp_wr));
      if (exp_wr) begin
        chk("pixel_addr", 64'(o_addr), 64'(mw));
        chk("pixel_data", 64'(o_dout), 64'(pix));
        mw++;
      end
      @(posedge clk); #1;
    end
    chk("gap_valid", 64'(o_so_valid), 64'd0);
    chk("gap_hold", 64'(o_so_data), 64'(bits[bits.size()-1]));
    chk("gap_ready", 64'(o_ready), 64'd1);
    chk("gap_wr", 64'(o_wr), 64'd0);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; pi_end = 1'b0; pi_data = 16'd0;
    pi_length = 2'd0; pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    // reset state
    chk("rst_valid", 64'(o_so_valid), 64'd0);
    chk("rst_data", 64'(o_so_data), 64'd0);
    chk("rst_wr", 64'(o_wr), 64'd0);
    chk("rst_addr", 64'(o_addr), 64'd0);
    chk("rst_dout", 64'(o_dout), 64'd0);
    chk("rst_finish", 64'(o_finish), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    reset = 1'b0;

    // directed frames
    run_frame(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    run_frame(16'h1234, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    run_frame(16'hBEEF, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // randomized frames
    for (int n = 0; n < 12; n++)
      run_frame(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 1'($urandom), 1'b0, 1'b0);

    // load and pi_end together: frame only, no fill afterwards
    run_frame(16'h5A3C, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("no_fill_ready", 64'(o_ready), 64'd1);
    chk("no_fill_wr", 64'(o_wr), 64'd0);

    // three one-pixel frames then zero-fill to the top of memory
    do_reset();
    for (int n = 0; n < 3; n++)
      run_frame(16'($urandom), 2'd0, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    pi_end = 1'b1;
    @(posedge clk); #1;
    pi_end = 1'b0;
    chk("fill_start_wr", 64'(o_wr), 64'd0);
    for (int a = mw; a < 256; a++) begin
      @(posedge clk); #1;
      chk("fill_wr", 64'(o_wr), 64'd1);
      chk("fill_addr", 64'(o_addr), 64'(a));
      chk("fill_data", 64'(o_dout), 64'd0);
      chk("fill_finish_low", 64'(o_finish), 64'd0);
    end
    @(posedge clk); #1;
    chk("finish_rise", 64'(o_finish), 64'd1);
    chk("finish_wr", 64'(o_wr), 64'd0);
    load = 1'b1; pi_end = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("done_valid", 64'(o_so_valid), 64'd0);
      chk("done_finish", 64'(o_finish), 64'd1);
      chk("done_ready", 64'(o_ready), 64'd0);
      chk("done_wr", 64'(o_wr), 64'd0);
    end
    load = 1'b0; pi_end = 1'b0;

    // reset in the middle of a fill
    do_reset();
    pi_end = 1'b1;
    @(posedge clk); #1;
    pi_end = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midfill_wr", 64'(o_wr), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_wr", 64'(o_wr), 64'd0);
    chk("abort_addr", 64'(o_addr), 64'd0);
    chk("abort_ready", 64'(o_ready), 64'd1);
    @(posedge clk); #1;
    chk("abort_quiet", 64'(o_wr), 64'd0);

    // small memory: overflow suppression then immediate DONE
    do_reset();
    sel = 1'b1; depth = 4;
    for (int n = 0; n < 5; n++)
      run_frame(16'($urandom), 2'd0, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    chk("small_wcount", 64'(mw), 64'd4);
    pi_end = 1'b1;
    @(posedge clk); #1;
    pi_end = 1'b0;
    chk("small_done_ready", 64'(o_ready), 64'd0);
    chk("small_done_wr", 64'(o_wr), 64'd0);
    @(posedge clk); #1;
    chk("small_finish", 64'(o_finish), 64'd1);
    chk("small_finish_wr", 64'(o_wr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
